mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller sitting directly downstream of the EX/MEM pipeline register. It consumes that register's outputs (ALU result, store data, control bits, destination register), runs a req/ack handshake to a variable-latency data memory, stalls upstream stages while an access is outstanding, and presents registered write-back data and control to the MEM/WB register. It also converts misaligned or timed-out accesses into pipeline bubbles and raises a sticky fault flag.

## Interface
- N, 32, data/address width
- AW, 10, word-address width driven to data memory
- TIMEOUT, 15, max WAIT cycles without ack before abort (1..255)

- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- AluResult_i  in  N  byte address (loads/stores) or ALU result
- RD2_i  in  N  store data
- MemWE_i  in  1  store
- WBSelect_i  in  1  1 = load (write back memory data), 0 = write back ALU result
- RF_WE_i  in  1  register-file write enable
- A3_i  in  4  destination register
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  write request, registered
- mem_addr_o  out  AW  word address = AluResult_i[AW+1:2], latched
- mem_wdata_o  out  N  latched store data
- mem_rdata_i  in  N  read data, valid in ack cycle
- mem_ack_i  in  1  single-cycle completion pulse
- stall_o  out  1  combinational, freezes EX/MEM and earlier stages
- WBData_o  out  N  write-back data to MEM/WB
- RF_WE_o  out  1  write-back enable (0 = bubble)
- A3_o  out  4  write-back destination
- fault_o  out  1  sticky misalign/timeout flag

## Operation
- access = MemWE_i | WBSelect_i; misaligned = access & (AluResult_i[1:0] != 0).
- States: IDLE, WAIT.
- IDLE, no access: at edge WBData_o <= AluResult_i, RF_WE_o <= RF_WE_i, A3_o <= A3_i; stall_o = 0.
- IDLE, misaligned: no request; fault_o <= 1; RF_WE_o <= 0; stall_o = 0; stay IDLE.
- IDLE, aligned access: stall_o = 1; at edge latch address/wdata/we/RF_WE/A3/WBSelect, mem_req_o <= 1, RF_WE_o <= 0, counter <= 0, go WAIT.
- WAIT, no ack: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable; stall_o = 1; RF_WE_o <= 0; counter += 1.
- WAIT, mem_ack_i = 1: stall_o = 0 same cycle; at edge mem_req_o <= 0, WBData_o <= latched WBSelect ? mem_rdata_i : latched address (full N bits), RF_WE_o <= latched RF_WE, A3_o <= latched A3, go IDLE. Stores write back ALU value only if RF_WE set.
- WAIT, counter == TIMEOUT-1 and no ack: stall_o = 0; at edge mem_req_o <= 0, fault_o <= 1, RF_WE_o <= 0, go IDLE. Ack coinciding with timeout cycle wins (normal completion).
- mem_ack_i in IDLE ignored.
- fault_o cleared only by RST.

## Timing
- Reset (async): state IDLE, counter 0, all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, WBData_o, RF_WE_o, A3_o, fault_o); stall_o = 0 while RST high. Reset during WAIT drops mem_req_o immediately.
- Non-memory latency: 1 edge, no stall.
- Memory latency: request asserted 1 cycle after instruction presented; result registered at the edge ending the ack cycle; minimum 2 cycles (ack in first WAIT cycle), stall_o high exactly 1 + (WAIT cycles before ack).
- Upstream holds inputs stable while stall_o = 1; next instruction accepted in IDLE the cycle after the ack edge.
- Exactly one bubble (RF_WE_o = 0) per stalled cycle.

## Test plan
- Reset mid-WAIT: assert RST with mem_req_o = 1 -> mem_req_o, RF_WE_o, fault_o drop to 0 without clock edge; state IDLE after release.
- ALU op AluResult_i = 0x0000_002A, RF_WE_i = 1, A3_i = 5 -> next edge WBData_o = 0x2A, RF_WE_o = 1, A3_o = 5, stall_o never high.
- Load addr 0x0000_0010, ack after 3 WAIT cycles with mem_rdata_i = 0xDEAD_BEEF -> mem_addr_o = 4, stall_o high 4 cycles, then WBData_o = 0xDEAD_BEEF, RF_WE_o = 1; 4 bubbles before.
- Store addr 0x0000_0008, RD2_i = 0x1234_5678, ack in first WAIT cycle -> mem_we_o = 1, mem_wdata_o = 0x1234_5678, mem_addr_o = 2, stall 1 cycle, RF_WE_o = 0 after.
- Load addr 0x0000_0006 -> no mem_req_o, fault_o = 1 after edge, RF_WE_o = 0, no stall; next ALU op passes normally, fault_o stays 1.
- Load, no ack for TIMEOUT = 15 cycles -> mem_req_o drops after 15th WAIT cycle, fault_o = 1, stall_o low in that cycle; late ack in IDLE ignored; ack exactly on cycle 15 completes normally with fault_o = 0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller between EX/MEM and MEM/WB
// Runs a req/ack handshake to data memory, stalls upstream and turns bad accesses into bubbles.
module mem_stage_ctrl #(
  parameter int N       = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  AluResult_i,
  input  logic [N-1:0]  RD2_i,
  input  logic          MemWE_i,
  input  logic          WBSelect_i,
  input  logic          RF_WE_i,
  input  logic [3:0]    A3_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [N-1:0]  mem_wdata_o,
  input  logic [N-1:0]  mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_o,
  output logic [N-1:0]  WBData_o,
  output logic          RF_WE_o,
  output logic [3:0]    A3_o,
  output logic          fault_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_next;
  logic [7:0]   counter;
  logic [N-1:0] lat_addr;
  logic         lat_wbsel;
  logic         lat_rfwe;
  logic [3:0]   lat_a3;

  logic access, misaligned;
  logic start, complete, timeout, bad_access;

  assign access     = MemWE_i | WBSelect_i;
  assign misaligned = access & (AluResult_i[1:0] != 2'b00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    bad_access = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          bad_access = 1'b1;
        end else if (access) begin
          stall_o    = 1'b1;
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // An ack in the final timeout cycle still counts as a normal completion.
        if (mem_ack_i) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (counter == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (RST) stall_o = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      counter     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      WBData_o    <= '0;
      RF_WE_o     <= 1'b0;
      A3_o        <= '0;
      fault_o     <= 1'b0;
      lat_addr    <= '0;
      lat_wbsel   <= 1'b0;
      lat_rfwe    <= 1'b0;
      lat_a3      <= '0;
    end else begin
      if (state == IDLE) begin
        if (bad_access) begin
          fault_o <= 1'b1;
          RF_WE_o <= 1'b0;
        end else if (start) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= MemWE_i;
          mem_addr_o  <= AluResult_i[AW+1:2];
          mem_wdata_o <= RD2_i;
          lat_addr    <= AluResult_i;
          lat_wbsel   <= WBSelect_i;
          lat_rfwe    <= RF_WE_i;
          lat_a3      <= A3_i;
          RF_WE_o     <= 1'b0;
          counter     <= '0;
        end else begin
          WBData_o <= AluResult_i;
          RF_WE_o  <= RF_WE_i;
          A3_o     <= A3_i;
        end
      end else begin
        if (complete) begin
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
          WBData_o  <= lat_wbsel ? mem_rdata_i : lat_addr;
          RF_WE_o   <= lat_rfwe;
          A3_o      <= lat_a3;
        end else if (timeout) begin
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
          fault_o   <= 1'b1;
          RF_WE_o   <= 1'b0;
        end else begin
          RF_WE_o <= 1'b0;
          counter <= counter + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] AluResult_i, RD2_i, mem_wdata_o, mem_rdata_i, WBData_o;
  logic        MemWE_i, WBSelect_i, RF_WE_i, mem_req_o, mem_we_o, mem_ack_i;
  logic        stall_o, RF_WE_o, fault_o;
  logic [3:0]  A3_i, A3_o;
  logic [9:0]  mem_addr_o;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.N(32), .AW(10), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .AluResult_i(AluResult_i), .RD2_i(RD2_i),
    .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i), .RF_WE_i(RF_WE_i), .A3_i(A3_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .WBData_o(WBData_o), .RF_WE_o(RF_WE_o), .A3_o(A3_o),
    .fault_o(fault_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_nop();
    AluResult_i = 32'h0; RD2_i = 32'h0; MemWE_i = 1'b0; WBSelect_i = 1'b0;
    RF_WE_i = 1'b0; A3_i = 4'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic set_instr(input logic [31:0] addr, input logic [31:0] wd,
                           input logic we, input logic wbs, input logic rfwe,
                           input logic [3:0] a3);
    AluResult_i = addr; RD2_i = wd; MemWE_i = we; WBSelect_i = wbs;
    RF_WE_i = rfwe; A3_i = a3;
  endtask

  task automatic do_reset();
    set_nop();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    set_nop();
    RST = 1'b1;
    #2;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, WBData_o, RF_WE_o, A3_o, fault_o, stall_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%0h wd=%0h wb=%0h rfwe=%b a3=%0h f=%b st=%b expected all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, WBData_o, RF_WE_o, A3_o, fault_o, stall_o);
    end
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_alu();
    set_instr(32'h2A, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5);
    #1;
    chk("alu_stall", 32'(stall_o), 32'd0);
    tick();
    chk("alu_wbdata", WBData_o, 32'h2A);
    chk("alu_rfwe", 32'(RF_WE_o), 32'd1);
    chk("alu_a3", 32'(A3_o), 32'd5);
    chk("alu_req", 32'(mem_req_o), 32'd0);
    set_nop();
  endtask

  task automatic test_load();
    int stalls = 0;
    int bubbles = 0;
    set_instr(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 4'd7);
    #1;
    chk("load_idle_stall", 32'(stall_o), 32'd1);
    if (stall_o) stalls++;
    tick();
    chk("load_req", 32'(mem_req_o), 32'd1);
    chk("load_addr", 32'(mem_addr_o), 32'd4);
    chk("load_we", 32'(mem_we_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (stall_o) stalls++;
      if (!RF_WE_o) bubbles++;
      tick();
    end
    if (!RF_WE_o) bubbles++;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("load_ack_stall", 32'(stall_o), 32'd0);
    chk("load_stall_cycles", 32'(stalls), 32'd4);
    chk("load_bubbles", 32'(bubbles), 32'd4);
    tick();
    set_nop();
    chk("load_wbdata", WBData_o, 32'hDEADBEEF);
    chk("load_rfwe", 32'(RF_WE_o), 32'd1);
    chk("load_a3", 32'(A3_o), 32'd7);
    chk("load_req_drop", 32'(mem_req_o), 32'd0);
  endtask

  task automatic test_store();
    set_instr(32'h8, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'd2);
    #1;
    chk("store_idle_stall", 32'(stall_o), 32'd1);
    tick();
    chk("store_req", 32'(mem_req_o), 32'd1);
    chk("store_we", 32'(mem_we_o), 32'd1);
    chk("store_wdata", mem_wdata_o, 32'h12345678);
    chk("store_addr", 32'(mem_addr_o), 32'd2);
    mem_ack_i = 1'b1;
    #1;
    chk("store_ack_stall", 32'(stall_o), 32'd0);
    tick();
    set_nop();
    chk("store_rfwe", 32'(RF_WE_o), 32'd0);
    chk("store_req_drop", 32'(mem_req_o), 32'd0);
  endtask

  task automatic test_misaligned();
    set_instr(32'h6, 32'h0, 1'b0, 1'b1, 1'b1, 4'd9);
    #1;
    chk("mis_stall", 32'(stall_o), 32'd0);
    tick();
    chk("mis_req", 32'(mem_req_o), 32'd0);
    chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_rfwe", 32'(RF_WE_o), 32'd0);
    set_instr(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3);
    #1;
    chk("mis_next_stall", 32'(stall_o), 32'd0);
    tick();
    chk("mis_next_wbdata", WBData_o, 32'h55);
    chk("mis_next_rfwe", 32'(RF_WE_o), 32'd1);
    chk("mis_fault_sticky", 32'(fault_o), 32'd1);
    set_nop();
  endtask

  task automatic test_reset_mid_wait();
    set_instr(32'h40, 32'h0, 1'b0, 1'b1, 1'b1, 4'd4);
    tick();
    chk("rmw_req_before", 32'(mem_req_o), 32'd1);
    chk("rmw_fault_before", 32'(fault_o), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("rmw_req", 32'(mem_req_o), 32'd0);
    chk("rmw_rfwe", 32'(RF_WE_o), 32'd0);
    chk("rmw_fault", 32'(fault_o), 32'd0);
    chk("rmw_stall", 32'(stall_o), 32'd0);
    tick();
    RST = 1'b0;
    set_instr(32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 4'd6);
    #1;
    chk("rmw_idle_stall", 32'(stall_o), 32'd0);
    tick();
    chk("rmw_idle_wbdata", WBData_o, 32'h77);
    chk("rmw_idle_req", 32'(mem_req_o), 32'd0);
    set_nop();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    do_reset();
    set_instr(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 4'd8);
    #1;
    if (stall_o) stalls++;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (stall_o) stalls++;
      tick();
    end
    chk("to_stall_cycles", 32'(stalls), 32'd15);
    chk("to_last_stall", 32'(stall_o), 32'd0);
    chk("to_last_req", 32'(mem_req_o), 32'd1);
    tick();
    set_nop();
    chk("to_req_drop", 32'(mem_req_o), 32'd0);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_rfwe", 32'(RF_WE_o), 32'd0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_rfwe", 32'(RF_WE_o), 32'd0);
    chk("late_ack_wbdata", WBData_o, 32'h0);
  endtask

  task automatic test_ack_on_last();
    do_reset();
    set_instr(32'h24, 32'h0, 1'b0, 1'b1, 1'b1, 4'd11);
    tick();
    for (int i = 0; i < 14; i++) tick();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("ack15_stall", 32'(stall_o), 32'd0);
    tick();
    set_nop();
    chk("ack15_wbdata", WBData_o, 32'hCAFEF00D);
    chk("ack15_rfwe", 32'(RF_WE_o), 32'd1);
    chk("ack15_a3", 32'(A3_o), 32'd11);
    chk("ack15_fault", 32'(fault_o), 32'd0);
    chk("ack15_req", 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_reset_mid_wait();
    test_timeout();
    test_ack_on_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
